demux_1_4_32_reg: RTL and testbench

Registered 1-to-4 demultiplexer for 32-bit data, the distribution-side counterpart to the team's 4:1 select muxes. A single valid/ready input stream is steered by a 2-bit select into one of four output channels. Each channel has its own one-entry holding register and valid/ready handshake, so a stalled consumer only blocks traffic addressed to it. The block sits where one producer feeds four independent consumers, and it keeps per-channel beat counters for debug.

---
 rtl/demux_1_4_32_reg_pkg.sv | 19 +
 rtl/demux_1_4_32_reg_if.sv | 48 ++++
 rtl/demux_1_4_32_reg_chan_reg.sv | 47 ++++
 rtl/demux_1_4_32_reg.sv | 75 +++++++
 tb/tb_demux_1_4_32_reg.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/demux_1_4_32_reg_pkg.sv
// -----------------------------------------------------------------------------
// demux_1_4_32_reg_pkg
// Shared constants and types for the registered 1-to-4 demultiplexer.
//   DW_DEF  : default data width of the input and every output channel
//   CW_DEF  : default width of each per-channel beat counter
//   NUM_CH  : number of output channels
//   SEL_W   : width of the channel select
//   chan_idx_t : channel index type used for in_sel
// -----------------------------------------------------------------------------
package demux_1_4_32_reg_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] chan_idx_t;

endpackage

// File: rtl/demux_1_4_32_reg_if.sv
// -----------------------------------------------------------------------------
// demux_1_4_32_reg_if
// Bus bundle for the 1-to-4 demultiplexer: one valid/ready input stream and
// four valid/ready output channels plus the per-channel beat counters.
//   in_data/in_sel/in_valid/in_ready : producer-side stream
//   out_data_0..3/out_valid/out_ready : consumer-side channels
//   beat_cnt_0..3                     : accepted beats per channel (debug)
// Modports:
//   slave  : the demultiplexer itself
//   master : the producer/consumer environment around it
// -----------------------------------------------------------------------------
interface demux_1_4_32_reg_if
  import demux_1_4_32_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) ();

  logic [DW-1:0]     in_data;
  chan_idx_t         in_sel;
  logic              in_valid;
  logic              in_ready;

  logic [DW-1:0]     out_data_0;
  logic [DW-1:0]     out_data_1;
  logic [DW-1:0]     out_data_2;
  logic [DW-1:0]     out_data_3;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;

  logic [CW-1:0]     beat_cnt_0;
  logic [CW-1:0]     beat_cnt_1;
  logic [CW-1:0]     beat_cnt_2;
  logic [CW-1:0]     beat_cnt_3;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data_0, out_data_1, out_data_2, out_data_3,
           out_valid, beat_cnt_0, beat_cnt_1, beat_cnt_2, beat_cnt_3
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data_0, out_data_1, out_data_2, out_data_3,
           out_valid, beat_cnt_0, beat_cnt_1, beat_cnt_2, beat_cnt_3
  );

endinterface

// File: rtl/demux_1_4_32_reg_chan_reg.sv
// -----------------------------------------------------------------------------
// demux_chan_reg
// One-entry holding register for a single output channel, with its own
// valid flag and beat counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of the valid flag (data/counter kept)
//   load       : accept load_data into the register this edge
//   drain      : consumer ready for this channel
//   load_data  : word to capture on load
//   data_q     : held word (stale while valid_q=0)
//   valid_q    : register full
//   cnt_q      : beats loaded since reset, wraps modulo 2^CW
// -----------------------------------------------------------------------------
module demux_chan_reg #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] data_q,
  output logic          valid_q,
  output logic [CW-1:0] cnt_q
);

  // A load wins over a drain on the same edge, so a channel streaming at
  // full rate keeps valid high while its word is replaced every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      valid_q <= 1'b1;
      cnt_q   <= cnt_q + CW'(1);
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_4_32_reg.sv
// -----------------------------------------------------------------------------
// demux_1_4_32_reg
// Registered 1-to-4 demultiplexer. A single valid/ready input stream is
// steered by in_sel into one of four channel registers, each with its own
// valid/ready handshake so a stalled consumer only blocks its own traffic.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 1 = input may be accepted; held words drain regardless
//   flush      : clears all channel valids next edge, blocks accept
//   bus        : demux_1_4_32_reg_if.slave (stream, channels, counters)
// -----------------------------------------------------------------------------
module demux_1_4_32_reg
  import demux_1_4_32_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  demux_1_4_32_reg_if.slave   bus
);

  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] load;
  logic [DW-1:0]     data_q [NUM_CH];
  logic [CW-1:0]     cnt_q  [NUM_CH];
  logic              sel_free;
  logic              in_ready;
  logic              accept;

  // The addressed channel can take a beat if it is empty or is being
  // drained on this same edge. in_ready is forced low during reset.
  always_comb begin
    sel_free = !valid_q[bus.in_sel] || bus.out_ready[bus.in_sel];
    in_ready = rst_n && enable && !flush && sel_free;
    accept   = bus.in_valid && in_ready;
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept && (bus.in_sel == chan_idx_t'(k));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_reg #(
      .DW(DW),
      .CW(CW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load      (load[k]),
      .drain     (bus.out_ready[k]),
      .load_data (bus.in_data),
      .data_q    (data_q[k]),
      .valid_q   (valid_q[k]),
      .cnt_q     (cnt_q[k])
    );
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_data_0 = data_q[0];
  assign bus.out_data_1 = data_q[1];
  assign bus.out_data_2 = data_q[2];
  assign bus.out_data_3 = data_q[3];
  assign bus.beat_cnt_0 = cnt_q[0];
  assign bus.beat_cnt_1 = cnt_q[1];
  assign bus.beat_cnt_2 = cnt_q[2];
  assign bus.beat_cnt_3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1_4_32_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1_4_32_reg
// Directed self-checking bench for demux_1_4_32_reg: reset, streaming,
// backpressure isolation, same-cycle drain/reload, flush, enable, counter
// wrap and asynchronous reset mid-burst.
// -----------------------------------------------------------------------------
module tb_demux_1_4_32_reg;

  logic clk;
  logic rst_n;
  logic enable;
  logic flush;

  int n_checks;
  int n_fail;

  demux_1_4_32_reg_if #(.DW(32), .CW(16)) bus ();

  demux_1_4_32_reg #(
    .DW(32),
    .CW(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .flush  (flush),
    .bus    (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all inputs, then let the combinational in_ready settle.
  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [31:0] data, input logic en,
                               input logic fl, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = data;
    enable        = en;
    flush         = fl;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0000);
    #1;

    // Reset state; enable=1 with all channels empty, yet in_ready held low
    checkOutput("rst_in_ready",  32'(bus.in_ready),   32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid),  32'h0);
    checkOutput("rst_cnt0",      32'(bus.beat_cnt_0), 32'h0);
    checkOutput("rst_cnt3",      32'(bus.beat_cnt_3), 32'h0);
    checkOutput("rst_data2",     bus.out_data_2,      32'h0);

    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Streaming to channel 2 with its consumer always ready
    applyStimulus(1'b1, 2'd2, 32'hA000_0001, 1'b1, 1'b0, 4'b0100);
    checkOutput("stream_rdy1", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("stream_d1", bus.out_data_2, 32'hA000_0001);
    checkOutput("stream_v1", 32'(bus.out_valid), 32'b0100);
    applyStimulus(1'b1, 2'd2, 32'hA000_0002, 1'b1, 1'b0, 4'b0100);
    checkOutput("stream_rdy2", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("stream_d2", bus.out_data_2, 32'hA000_0002);
    applyStimulus(1'b1, 2'd2, 32'hA000_0003, 1'b1, 1'b0, 4'b0100);
    checkOutput("stream_rdy3", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("stream_d3", bus.out_data_2, 32'hA000_0003);
    applyStimulus(1'b1, 2'd2, 32'hA000_0004, 1'b1, 1'b0, 4'b0100);
    checkOutput("stream_rdy4", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("stream_d4", bus.out_data_2, 32'hA000_0004);
    checkOutput("stream_v4", 32'(bus.out_valid), 32'b0100);
    applyStimulus(1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 4'b0100);
    tick();
    checkOutput("stream_drained", 32'(bus.out_valid), 32'b0000);
    checkOutput("stream_cnt2", 32'(bus.beat_cnt_2), 32'd4);
    checkOutput("stream_cnt0", 32'(bus.beat_cnt_0), 32'd0);
    checkOutput("stream_data0", bus.out_data_0, 32'h0);

    // Backpressure isolation on channel 1
    applyStimulus(1'b1, 2'd1, 32'h1111_1111, 1'b1, 1'b0, 4'b0000);
    checkOutput("bp_rdy_first", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("bp_v_first", 32'(bus.out_valid), 32'b0010);
    applyStimulus(1'b1, 2'd1, 32'h2222_2222, 1'b1, 1'b0, 4'b0000);
    checkOutput("bp_rdy_stall", 32'(bus.in_ready), 32'h0);
    tick();
    checkOutput("bp_d_held", bus.out_data_1, 32'h1111_1111);
    checkOutput("bp_cnt_held", 32'(bus.beat_cnt_1), 32'd1);
    applyStimulus(1'b1, 2'd1, 32'h2222_2222, 1'b1, 1'b0, 4'b0010);
    checkOutput("bp_rdy_release", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("bp_d_reload", bus.out_data_1, 32'h2222_2222);
    checkOutput("bp_cnt_reload", 32'(bus.beat_cnt_1), 32'd2);
    applyStimulus(1'b1, 2'd3, 32'h3333_3333, 1'b1, 1'b0, 4'b0000);
    checkOutput("bp_rdy_ch3", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("bp_v_1010", 32'(bus.out_valid), 32'b1010);
    checkOutput("bp_d_ch3", bus.out_data_3, 32'h3333_3333);

    // Same-cycle drain and reload on channel 0
    applyStimulus(1'b1, 2'd0, 32'hC000_0001, 1'b1, 1'b0, 4'b0000);
    tick();
    checkOutput("rl_v_before", 32'(bus.out_valid), 32'b1011);
    applyStimulus(1'b1, 2'd0, 32'hC000_0002, 1'b1, 1'b0, 4'b0001);
    checkOutput("rl_rdy", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("rl_v_after", 32'(bus.out_valid), 32'b1011);
    checkOutput("rl_d_after", bus.out_data_0, 32'hC000_0002);
    checkOutput("rl_cnt0", 32'(bus.beat_cnt_0), 32'd2);

    // Drain channel 1 so only channels 0 and 3 are full, then flush
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0010);
    tick();
    checkOutput("fl_v_before", 32'(bus.out_valid), 32'b1001);
    applyStimulus(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'b0000);
    checkOutput("fl_rdy", 32'(bus.in_ready), 32'h0);
    tick();
    checkOutput("fl_v_after", 32'(bus.out_valid), 32'b0000);
    checkOutput("fl_cnt2", 32'(bus.beat_cnt_2), 32'd4);
    checkOutput("fl_d2", bus.out_data_2, 32'hA000_0004);
    checkOutput("fl_d0", bus.out_data_0, 32'hC000_0002);

    // enable=0 blocks every channel even though all are empty
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 2'(s), 32'h5555_5555, 1'b0, 1'b0, 4'b0000);
      checkOutput($sformatf("en_rdy_sel%0d", s), 32'(bus.in_ready), 32'h0);
    end
    tick();
    checkOutput("en_v", 32'(bus.out_valid), 32'b0000);
    checkOutput("en_cnt0", 32'(bus.beat_cnt_0), 32'd2);

    // Counter wrap on channel 3: count is 1, add 65534 beats to reach 0xFFFF
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(1'b1, 2'd3, 32'(i), 1'b1, 1'b0, 4'b1000);
      tick();
    end
    checkOutput("wrap_cnt_ffff", 32'(bus.beat_cnt_3), 32'h0000_FFFF);
    checkOutput("wrap_d_last", bus.out_data_3, 32'd65533);
    applyStimulus(1'b1, 2'd3, 32'hF00D_F00D, 1'b1, 1'b0, 4'b1000);
    tick();
    checkOutput("wrap_cnt_zero", 32'(bus.beat_cnt_3), 32'h0);
    checkOutput("wrap_d", bus.out_data_3, 32'hF00D_F00D);
    checkOutput("wrap_v", 32'(bus.out_valid), 32'b1000);

    // Asynchronous reset in the middle of a burst, checked before any edge
    applyStimulus(1'b1, 2'd3, 32'h1234_5678, 1'b1, 1'b0, 4'b1000);
    tick();
    checkOutput("ar_cnt_before", 32'(bus.beat_cnt_3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_v", 32'(bus.out_valid), 32'b0000);
    checkOutput("ar_cnt3", 32'(bus.beat_cnt_3), 32'h0);
    checkOutput("ar_cnt0", 32'(bus.beat_cnt_0), 32'h0);
    checkOutput("ar_d3", bus.out_data_3, 32'h0);
    checkOutput("ar_rdy", 32'(bus.in_ready), 32'h0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
